// File: rtl/regfile_scheduler.sv
// Write-port arbiter and snapshot sweeper for the 16-entry card regfile.
// Round-robin grants between two requesters; writes are frozen while a sweep streams.
module regfile_scheduler #(
    parameter int DATA_WIDTH  = 14,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_ENTRIES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_a,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  gnt_a,
    input  logic                  req_b,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  gnt_b,
    input  logic                  sweep_start,
    output logic                  regfile_w_enable,
    output logic [ADDR_WIDTH-1:0] regfile_w_address,
    output logic [DATA_WIDTH-1:0] regfile_w_data,
    output logic [ADDR_WIDTH-1:0] regfile_r_address,
    input  logic [DATA_WIDTH-1:0] regfile_r_data,
    output logic                  sweep_valid,
    output logic [ADDR_WIDTH-1:0] sweep_index,
    output logic [DATA_WIDTH-1:0] sweep_data,
    output logic                  sweep_done,
    output logic                  busy
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_raddr;
    logic                    r_rd_vld;
    logic [ADDR_WIDTH-1:0]   r_rd_idx;
    logic                    r_last_b;
    logic                    r_gnt_a, r_gnt_b, r_wen;
    logic [ADDR_WIDTH-1:0]   r_waddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_sv, r_sdone;
    logic [ADDR_WIDTH-1:0]   r_sidx;
    logic [DATA_WIDTH-1:0]   r_sdata;

    logic w_arb_ok, w_elig_a, w_elig_b, w_pick_a, w_pick_b;

    // A side granted last edge sits out one arbitration so the other side gets a turn.
    assign w_arb_ok = (r_state == IDLE) && !sweep_start;
    assign w_elig_a = req_a && !r_gnt_a;
    assign w_elig_b = req_b && !r_gnt_b;
    assign w_pick_a = w_arb_ok && w_elig_a && (!w_elig_b || r_last_b);
    assign w_pick_b = w_arb_ok && w_elig_b && (!w_elig_a || !r_last_b);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (sweep_start) w_state_nxt = READ;
            READ:    if (r_raddr == LAST) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raddr  <= '0;
            r_rd_vld <= 1'b0;
            r_rd_idx <= '0;
            r_last_b <= 1'b1;
            r_gnt_a  <= 1'b0;
            r_gnt_b  <= 1'b0;
            r_wen    <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_sv     <= 1'b0;
            r_sdone  <= 1'b0;
            r_sidx   <= '0;
            r_sdata  <= '0;
        end else begin
            if (r_state == IDLE && sweep_start)          r_raddr <= '0;
            else if (r_state == READ && r_raddr != LAST) r_raddr <= r_raddr + 1'b1;

            // Address issued last cycle -> regfile data valid now -> registered beat next edge.
            r_rd_vld <= (r_state == READ);
            r_rd_idx <= r_raddr;
            r_sv     <= r_rd_vld;
            r_sidx   <= r_rd_idx;
            r_sdone  <= r_rd_vld && (r_rd_idx == LAST);
            if (r_rd_vld) r_sdata <= regfile_r_data;

            r_gnt_a <= w_pick_a;
            r_gnt_b <= w_pick_b;
            r_wen   <= w_pick_a || w_pick_b;
            if (w_pick_a) begin
                r_waddr  <= a_addr;
                r_wdata  <= a_data;
                r_last_b <= 1'b0;
            end else if (w_pick_b) begin
                r_waddr  <= b_addr;
                r_wdata  <= b_data;
                r_last_b <= 1'b1;
            end
        end
    end

    assign gnt_a             = r_gnt_a;
    assign gnt_b             = r_gnt_b;
    assign regfile_w_enable  = r_wen;
    assign regfile_w_address = r_waddr;
    assign regfile_w_data    = r_wdata;
    assign regfile_r_address = r_raddr;
    assign sweep_valid       = r_sv;
    assign sweep_index       = r_sidx;
    assign sweep_data        = r_sdata;
    assign sweep_done        = r_sdone;
    assign busy              = (r_state != IDLE);
endmodule

// File: tb/tb_regfile_scheduler.sv
// Directed bench for regfile_scheduler with a behavioural sync-read regfile attached.
module tb_regfile_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b, sweep_start;
    logic [3:0]  a_addr, b_addr;
    logic [13:0] a_data, b_data;
    logic        gnt_a, gnt_b, regfile_w_enable, sweep_valid, sweep_done, busy;
    logic [3:0]  regfile_w_address, regfile_r_address, sweep_index;
    logic [13:0] regfile_w_data, regfile_r_data, sweep_data;

    logic [13:0] mem     [16];
    logic [13:0] exp_mem [16];
    int errors = 0;
    int checks = 0;

    regfile_scheduler dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .a_addr(a_addr), .a_data(a_data), .gnt_a(gnt_a),
        .req_b(req_b), .b_addr(b_addr), .b_data(b_data), .gnt_b(gnt_b),
        .sweep_start(sweep_start),
        .regfile_w_enable(regfile_w_enable), .regfile_w_address(regfile_w_address),
        .regfile_w_data(regfile_w_data), .regfile_r_address(regfile_r_address),
        .regfile_r_data(regfile_r_data),
        .sweep_valid(sweep_valid), .sweep_index(sweep_index), .sweep_data(sweep_data),
        .sweep_done(sweep_done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (regfile_w_enable) mem[regfile_w_address] <= regfile_w_data;
        regfile_r_data <= mem[regfile_r_address];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wen"},   32'(regfile_w_enable), 0);
        chk({tag, "_waddr"}, 32'(regfile_w_address), 0);
        chk({tag, "_wdata"}, 32'(regfile_w_data), 0);
        chk({tag, "_gnts"},  32'({gnt_a, gnt_b}), 0);
        chk({tag, "_raddr"}, 32'(regfile_r_address), 0);
        chk({tag, "_sv"},    32'(sweep_valid), 0);
        chk({tag, "_sidx"},  32'(sweep_index), 0);
        chk({tag, "_sdata"}, 32'(sweep_data), 0);
        chk({tag, "_sdone"}, 32'(sweep_done), 0);
        chk({tag, "_busy"},  32'(busy), 0);
    endtask

    // Start a sweep and check every beat; optional hooks raise req_b, re-pulse
    // sweep_start, or assert rst right after a given beat (-1 disables).
    task automatic do_sweep(input string tag, input int b_beat, input int s_beat, input int rst_beat);
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        chk({tag, "_busy0"}, 32'(busy), 1);
        chk({tag, "_raddr0"}, 32'(regfile_r_address), 0);
        step();
        chk({tag, "_lat"}, 32'(sweep_valid), 0);
        for (int i = 0; i < 16; i++) begin
            step();
            sweep_start = 1'b0;
            chk($sformatf("%s_v%0d", tag, i),    32'(sweep_valid), 1);
            chk($sformatf("%s_idx%0d", tag, i),  32'(sweep_index), 32'(i));
            chk($sformatf("%s_dat%0d", tag, i),  32'(sweep_data), 32'(exp_mem[i]));
            chk($sformatf("%s_done%0d", tag, i), 32'(sweep_done), 32'(i == 15));
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'(i != 15));
            chk($sformatf("%s_wen%0d", tag, i),  32'(regfile_w_enable), 0);
            if (i == rst_beat) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk_zero({tag, "_rst"});
                step();
                chk({tag, "_rst_done"}, 32'({sweep_valid, sweep_done, busy}), 0);
                return;
            end
            if (i == b_beat) req_b = 1'b1;
            if (i == s_beat) sweep_start = 1'b1;
        end
        step();
        chk({tag, "_end_v"}, 32'(sweep_valid), 0);
        chk({tag, "_end_busy"}, 32'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        rst = 1'b1; req_a = 0; req_b = 0; sweep_start = 0;
        a_addr = 0; a_data = 0; b_addr = 0; b_data = 0;
        step();
        step();
        rst = 1'b0;
        chk_zero("reset");

        // Single A write
        req_a = 1; a_addr = 4'd3; a_data = 14'h0ABC;
        step();
        req_a = 0;
        chk("t1_wen", 32'(regfile_w_enable), 1);
        chk("t1_waddr", 32'(regfile_w_address), 3);
        chk("t1_wdata", 32'(regfile_w_data), 32'h0ABC);
        chk("t1_gnt_a", 32'(gnt_a), 1);
        chk("t1_gnt_b", 32'(gnt_b), 0);
        step();
        chk("t1_wen_off", 32'(regfile_w_enable), 0);

        // Both held; A was granted last, so B takes the first tie
        req_a = 1; a_addr = 4'd5; a_data = 14'h0111;
        req_b = 1; b_addr = 4'd6; b_data = 14'h0222;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t2_gnt%0d", i), 32'({gnt_a, gnt_b}), (i % 2 == 0) ? 32'b01 : 32'b10);
            chk($sformatf("t2_wdat%0d", i), 32'(regfile_w_data), (i % 2 == 0) ? 32'h222 : 32'h111);
            chk($sformatf("t2_wen%0d", i), 32'(regfile_w_enable), 1);
        end
        req_a = 0; req_b = 0;
        step();
        step();

        // Preload entry i = 3*i
        for (int i = 0; i < 16; i++) begin
            req_a = 1; a_addr = 4'(i); a_data = 14'(3 * i);
            exp_mem[i] = 14'(3 * i);
            step();
            req_a = 0;
            step();
        end
        chk("pre_mem5", 32'(mem[5]), 15);

        do_sweep("t3", -1, -1, -1);
        chk("t3_no_wr", 32'(regfile_w_enable), 0);

        // req_b raised mid-sweep waits for the sweep to finish
        b_addr = 4'd2; b_data = 14'h1555;
        do_sweep("t4", 4, -1, -1);
        chk("t4_gnt_b", 32'(gnt_b), 1);
        chk("t4_wen", 32'(regfile_w_enable), 1);
        chk("t4_waddr", 32'(regfile_w_address), 2);
        chk("t4_wdata", 32'(regfile_w_data), 32'h1555);
        req_b = 0;
        exp_mem[2] = 14'h1555;
        step();
        do_sweep("t4r", -1, -1, -1);

        // sweep_start and req_a together; extra start at beat 8 ignored
        req_a = 1; a_addr = 4'd7; a_data = 14'h0777;
        do_sweep("t5", -1, 8, -1);
        chk("t5_gnt_a", 32'(gnt_a), 1);
        chk("t5_waddr", 32'(regfile_w_address), 7);
        chk("t5_wdata", 32'(regfile_w_data), 32'h0777);
        req_a = 0;
        exp_mem[7] = 14'h0777;
        step();

        // Reset mid-sweep, then a clean sweep
        do_sweep("t6", -1, -1, 7);
        do_sweep("t6r", -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
